banked_mem_arb: RTL and testbench
=================================

# banked_mem_arb

Multi-port banked memory with per-bank round-robin arbitration and byte-enable writes. NUM_PORTS independent requesters issue valid/ready transactions. Each bank serves at most one access per cycle, and each response returns on the issuing port with a fixed latency. It is the next-generation replacement for the single-port banked memory, sitting between core/DMA request ports and on-chip storage.

## Interface
- DATA_WIDTH, 32, word width in bits; multiple of 8
- BYTE_ADDR_WIDTH, 8, word address bits inside one bank (depth 2^BYTE_ADDR_WIDTH)
- BANKS_ADDR_WIDTH, 2, bank select bits; NUM_BANKS = 2^BANKS_ADDR_WIDTH
- NUM_PORTS, 2, number of requester ports; ≥1
- ADDR_WIDTH (derived, local), BYTE_ADDR_WIDTH+BANKS_ADDR_WIDTH
- BE_WIDTH (derived, local), DATA_WIDTH/8
- CNT_WIDTH, 16, conflict counter width

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  reset, asynchronous, active-low
- req_valid  in  NUM_PORTS  request present, per port
- req_ready  out  NUM_PORTS  request accepted this cycle
- req_wen  in  NUM_PORTS  1 = write, 0 = read
- req_addr  in  NUM_PORTS*ADDR_WIDTH  port p at [p*ADDR_WIDTH +: ADDR_WIDTH]; bank = upper BANKS_ADDR_WIDTH bits
- req_wdata  in  NUM_PORTS*DATA_WIDTH  write data
- req_be  in  NUM_PORTS*BE_WIDTH  byte enables, writes only
- rsp_valid  out  NUM_PORTS  response (read data or write ack)
- rsp_rdata  out  NUM_PORTS*DATA_WIDTH  read data; all-zero for write acks
- conflict_cnt  out  CNT_WIDTH  saturating count of conflict cycles

## Operation
- Handshake: a transaction transfers when req_valid[p] && req_ready[p]. The requester holds all request fields stable while valid && !ready.
- Bank select: addr[BYTE_ADDR_WIDTH +: BANKS_ADDR_WIDTH]. Word offset: addr[0 +: BYTE_ADDR_WIDTH].
- Per-bank arbitration:
  - Among valid ports targeting a bank, the grant goes to the first port at or after rr_ptr[bank], searching cyclically upward.
  - After a grant to port g, rr_ptr[bank] ← (g+1) mod NUM_PORTS. Pointers for banks with no grant are unchanged.
- req_ready[p] = 1 iff port p holds the grant for its bank. Different banks are served in parallel, so up to min(NUM_PORTS, NUM_BANKS) grants per cycle.
- Write: bytes with req_be=1 are updated and the others are retained. be=0 performs no write but still produces an ack.
- Every accepted transaction produces exactly one rsp_valid pulse on the issuing port. Responses on a port return in issue order.
- Conflict cycle: any cycle in which some port has req_valid=1 and req_ready=0. conflict_cnt increments by 1 per conflict cycle and saturates at all-ones.
- Memory contents are not reset; a read of an unwritten location returns X in simulation.

## Timing
- req_ready is combinational from req_valid/req_addr and the registered rr_ptr. No ready-to-valid dependency is allowed in the requester.
- Latency: a handshake at edge t produces rsp_valid=1 during the cycle after edge t+2. Stage 1 is the RAM access; stage 2 is the output register. This latency is fixed regardless of conflicts.
- Throughput: one transaction per port per cycle when no bank conflict exists.
- Ordering:
  - A write at edge t followed by a read of the same address at edge t+1 from any port returns the new data.
  - Same-bank same-cycle read/write from different ports cannot occur, because arbitration serialises them.
- Reset values (asynchronous, while rst_n=0):
  - req_ready is 0.
  - rsp_valid, rsp_rdata, conflict_cnt, and all rr_ptr are 0.
  - Pipeline valid bits are cleared.
- Reset mid-operation: in-flight responses are dropped without a pulse. Memory is left as written; a write in progress at assertion may or may not land.

## Structure
- Shared package banked_mem_pkg holds:
  - the default parameter constants;
  - the function bank_of(addr);
  - the typedef of the per-port pipeline entry {valid, wen, port_id}.
- Sub-module banked_mem_bank: one bank, single-port, synchronous read, 1-cycle latency, per-byte write enable. There is one instance per bank in a generate loop.
- Arbitration and the rr_ptr registers stay in the top level, one generate iteration per bank.

## Test plan
- Defaults. Port0 writes 0xDEADBEEF to addr 0x005 (be=0xF), then reads 0x005 → rsp_valid[0] 2 cycles after each handshake; read data = 0xDEADBEEF, write-ack rdata = 0.
- Byte enables. Write 0xFFFFFFFF to addr 0x110, then write 0x00000000 with be=0x5, then read → 0xFF00FF00.
- Parallel banks. Port0 reads addr 0x010 (bank0) while port1 reads addr 0x110 (bank1) in the same cycle → both ready=1, both responses in the same cycle, conflict_cnt unchanged.
- Conflict with round-robin:
  - Setup: both ports continuously request bank 2 for 4 cycles.
  - Required grants: alternate port0, port1, port0, port1.
  - Required counter: conflict_cnt = 4 and every response is correct.
- Saturation and reset:
  - Run with CNT_WIDTH=4 under sustained conflict for 20 cycles → conflict_cnt holds 0xF.
  - Assert rst_n mid-run with 2 reads in flight → no rsp_valid pulse appears; all outputs are 0 immediately, independent of clk.
  - Re-read a location written before reset → prior data is returned.

Source files
------------

// File: rtl/banked_mem_pkg.sv
// Shared constants, types and helpers for the banked multi-port memory.
package banked_mem_pkg;

  localparam int DEF_DATA_WIDTH       = 32;
  localparam int DEF_BYTE_ADDR_WIDTH  = 8;
  localparam int DEF_BANKS_ADDR_WIDTH = 2;
  localparam int DEF_NUM_PORTS        = 2;
  localparam int DEF_CNT_WIDTH        = 16;
  localparam int PORT_ID_WIDTH        = 8;

  typedef struct packed {
    logic                     valid;
    logic                     wen;
    logic [PORT_ID_WIDTH-1:0] port_id;
  } pipe_entry_t;

  function automatic logic [31:0] bank_of(input logic [31:0] addr,
                                          input int          byte_w,
                                          input int          bank_w);
    logic [31:0] mask;
    mask = (32'd1 << bank_w) - 32'd1;
    return (addr >> byte_w) & mask;
  endfunction

endpackage

// File: rtl/banked_mem_bank.sv
// One storage bank: single-port, synchronous read with one cycle of latency,
// per-byte write enable. Contents are intentionally not reset.
module banked_mem_bank #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 8,
  parameter int BE_WIDTH   = DATA_WIDTH / 8
) (
  input  logic                  clk,
  input  logic                  en,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic [BE_WIDTH-1:0]   be,
  output logic [DATA_WIDTH-1:0] rdata
);

  logic [DATA_WIDTH-1:0] mem_q [1 << ADDR_WIDTH];
  logic [DATA_WIDTH-1:0] rdata_q;

  // Byte-masked write or registered read, one access per cycle
  always_ff @(posedge clk) begin
    if (en) begin
      if (we) begin
        for (int i = 0; i < BE_WIDTH; i++) begin
          if (be[i]) begin
            mem_q[addr][i*8 +: 8] <= wdata[i*8 +: 8];
          end
        end
      end else begin
        rdata_q <= mem_q[addr];
      end
    end
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/banked_mem_arb.sv
// Multi-port banked memory: per-bank round-robin arbitration, byte-enable
// writes, fixed-latency in-order responses and a saturating conflict counter.
module banked_mem_arb
  import banked_mem_pkg::*;
#(
  parameter int DATA_WIDTH         = DEF_DATA_WIDTH,
  parameter int BYTE_ADDR_WIDTH    = DEF_BYTE_ADDR_WIDTH,
  parameter int BANKS_ADDR_WIDTH   = DEF_BANKS_ADDR_WIDTH,
  parameter int NUM_PORTS          = DEF_NUM_PORTS,
  parameter int CNT_WIDTH          = DEF_CNT_WIDTH,
  localparam int ADDR_WIDTH        = BYTE_ADDR_WIDTH + BANKS_ADDR_WIDTH,
  localparam int BE_WIDTH          = DATA_WIDTH / 8
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic [NUM_PORTS-1:0]            req_valid,
  output logic [NUM_PORTS-1:0]            req_ready,
  input  logic [NUM_PORTS-1:0]            req_wen,
  input  logic [NUM_PORTS*ADDR_WIDTH-1:0] req_addr,
  input  logic [NUM_PORTS*DATA_WIDTH-1:0] req_wdata,
  input  logic [NUM_PORTS*BE_WIDTH-1:0]   req_be,
  output logic [NUM_PORTS-1:0]            rsp_valid,
  output logic [NUM_PORTS*DATA_WIDTH-1:0] rsp_rdata,
  output logic [CNT_WIDTH-1:0]            conflict_cnt
);

  localparam int NUM_BANKS = 1 << BANKS_ADDR_WIDTH;
  localparam int PTR_W     = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;

  logic [NUM_PORTS-1:0][BANKS_ADDR_WIDTH-1:0] bank_sel_s;
  logic [NUM_BANKS-1:0][NUM_PORTS-1:0]        gnt_all_s;
  logic [NUM_BANKS-1:0]                       s2_valid_all_s;
  logic [NUM_BANKS-1:0]                       s2_wen_all_s;
  logic [NUM_BANKS-1:0][PORT_ID_WIDTH-1:0]    s2_port_all_s;
  logic [NUM_BANKS-1:0][DATA_WIDTH-1:0]       s2_data_all_s;

  logic [NUM_PORTS-1:0]                       req_ready_s;
  logic                                       conflict_s;
  logic                                       hit_v;
  logic [NUM_PORTS-1:0]                       rsp_valid_d, rsp_valid_q;
  logic [NUM_PORTS-1:0][DATA_WIDTH-1:0]       rsp_rdata_d, rsp_rdata_q;
  logic [CNT_WIDTH-1:0]                       conflict_cnt_d, conflict_cnt_q;

  // Decode the target bank of every port's request
  always_comb begin
    bank_sel_s = '0;
    for (int p = 0; p < NUM_PORTS; p++) begin
      bank_sel_s[p] = BANKS_ADDR_WIDTH'(bank_of(32'(req_addr[p*ADDR_WIDTH +: ADDR_WIDTH]),
                                                BYTE_ADDR_WIDTH, BANKS_ADDR_WIDTH));
    end
  end

  for (genvar b = 0; b < NUM_BANKS; b++) begin : g_bank
    logic [NUM_PORTS-1:0]       cand_s;
    logic [NUM_PORTS-1:0]       gnt_s;
    logic                       any_gnt_s;
    logic                       take_v;
    logic [PTR_W-1:0]           gnt_id_s;
    logic [PTR_W-1:0]           rr_ptr_d, rr_ptr_q;
    logic                       wen_s;
    logic [BYTE_ADDR_WIDTH-1:0] off_s;
    logic [DATA_WIDTH-1:0]      wdata_s;
    logic [BE_WIDTH-1:0]        be_s;
    logic [DATA_WIDTH-1:0]      bank_rdata_s;
    pipe_entry_t                s1_d, s1_q, s2_d, s2_q;
    logic [DATA_WIDTH-1:0]      s2_data_d, s2_data_q;

    // Round-robin pick: first candidate at/after rr_ptr, then wrap below it
    always_comb begin
      cand_s    = '0;
      gnt_s     = '0;
      any_gnt_s = 1'b0;
      take_v    = 1'b0;
      gnt_id_s  = '0;
      for (int p = 0; p < NUM_PORTS; p++) begin
        cand_s[p] = rst_n & req_valid[p] & (bank_sel_s[p] == BANKS_ADDR_WIDTH'(b));
      end
      for (int p = 0; p < NUM_PORTS; p++) begin
        take_v    = ~any_gnt_s & cand_s[p] & (p >= int'(rr_ptr_q));
        gnt_s[p]  = take_v;
        any_gnt_s = any_gnt_s | take_v;
        gnt_id_s  = take_v ? PTR_W'(p) : gnt_id_s;
      end
      for (int p = 0; p < NUM_PORTS; p++) begin
        take_v    = ~any_gnt_s & cand_s[p] & (p < int'(rr_ptr_q));
        gnt_s[p]  = gnt_s[p] | take_v;
        any_gnt_s = any_gnt_s | take_v;
        gnt_id_s  = take_v ? PTR_W'(p) : gnt_id_s;
      end
    end

    // Route the granted port's fields to the bank (grant is one-hot)
    always_comb begin
      wen_s   = 1'b0;
      off_s   = '0;
      wdata_s = '0;
      be_s    = '0;
      for (int p = 0; p < NUM_PORTS; p++) begin
        wen_s   = wen_s | (gnt_s[p] & req_wen[p]);
        off_s   = off_s | ({BYTE_ADDR_WIDTH{gnt_s[p]}} & req_addr[p*ADDR_WIDTH +: BYTE_ADDR_WIDTH]);
        wdata_s = wdata_s | ({DATA_WIDTH{gnt_s[p]}} & req_wdata[p*DATA_WIDTH +: DATA_WIDTH]);
        be_s    = be_s | ({BE_WIDTH{gnt_s[p]}} & req_be[p*BE_WIDTH +: BE_WIDTH]);
      end
    end

    // Next pointer and pipeline entries for this bank
    always_comb begin
      rr_ptr_d  = any_gnt_s ? ((gnt_id_s == PTR_W'(NUM_PORTS - 1)) ? '0 : gnt_id_s + PTR_W'(1))
                            : rr_ptr_q;
      s1_d      = '{valid: any_gnt_s, wen: wen_s, port_id: PORT_ID_WIDTH'(gnt_id_s)};
      s2_d      = s1_q;
      s2_data_d = bank_rdata_s;
    end

    // Pointer and pipeline state; entries are dropped on reset
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        rr_ptr_q  <= '0;
        s1_q      <= '0;
        s2_q      <= '0;
        s2_data_q <= '0;
      end else begin
        rr_ptr_q  <= rr_ptr_d;
        s1_q      <= s1_d;
        s2_q      <= s2_d;
        s2_data_q <= s2_data_d;
      end
    end

    banked_mem_bank #(
      .DATA_WIDTH (DATA_WIDTH),
      .ADDR_WIDTH (BYTE_ADDR_WIDTH),
      .BE_WIDTH   (BE_WIDTH)
    ) u_bank (
      .clk   (clk),
      .en    (any_gnt_s),
      .we    (any_gnt_s & wen_s),
      .addr  (off_s),
      .wdata (wdata_s),
      .be    (be_s),
      .rdata (bank_rdata_s)
    );

    assign gnt_all_s[b]      = gnt_s;
    assign s2_valid_all_s[b] = s2_q.valid;
    assign s2_wen_all_s[b]   = s2_q.wen;
    assign s2_port_all_s[b]  = s2_q.port_id;
    assign s2_data_all_s[b]  = s2_data_q;
  end

  // Ready, conflict detection and response steering back to issuing ports
  always_comb begin
    req_ready_s = '0;
    for (int b = 0; b < NUM_BANKS; b++) begin
      req_ready_s = req_ready_s | gnt_all_s[b];
    end
    conflict_s     = |(req_valid & ~req_ready_s);
    conflict_cnt_d = (conflict_s && (conflict_cnt_q != {CNT_WIDTH{1'b1}}))
                   ? conflict_cnt_q + CNT_WIDTH'(1) : conflict_cnt_q;
    rsp_valid_d = '0;
    rsp_rdata_d = '0;
    hit_v       = 1'b0;
    for (int p = 0; p < NUM_PORTS; p++) begin
      for (int b = 0; b < NUM_BANKS; b++) begin
        hit_v          = s2_valid_all_s[b] & (s2_port_all_s[b] == PORT_ID_WIDTH'(p));
        rsp_valid_d[p] = rsp_valid_d[p] | hit_v;
        // Write acks carry zero data
        rsp_rdata_d[p] = rsp_rdata_d[p] | ({DATA_WIDTH{hit_v & ~s2_wen_all_s[b]}} & s2_data_all_s[b]);
      end
    end
  end

  // Registered response and counter outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_valid_q    <= '0;
      rsp_rdata_q    <= '0;
      conflict_cnt_q <= '0;
    end else begin
      rsp_valid_q    <= rsp_valid_d;
      rsp_rdata_q    <= rsp_rdata_d;
      conflict_cnt_q <= conflict_cnt_d;
    end
  end

  assign req_ready    = req_ready_s;
  assign rsp_valid    = rsp_valid_q;
  assign rsp_rdata    = rsp_rdata_q;
  assign conflict_cnt = conflict_cnt_q;

endmodule

// File: tb/tb_banked_mem_arb.sv
// Scoreboard bench for banked_mem_arb: expected responses are queued per port
// at each handshake and compared when the DUT returns them.
module tb_banked_mem_arb;

  localparam int NP  = 2;
  localparam int AW  = 10;
  localparam int DW  = 32;
  localparam int BEW = 4;
  localparam int CW  = 4;

  typedef struct {
    logic [31:0] data;
    int          due;
  } exp_t;

  typedef struct {
    logic        w;
    logic [9:0]  a;
    logic [31:0] d;
  } req_t;

  logic             clk;
  logic             rst_n;
  logic [NP-1:0]    req_valid;
  logic [NP-1:0]    req_ready;
  logic [NP-1:0]    req_wen;
  logic [NP*AW-1:0] req_addr;
  logic [NP*DW-1:0] req_wdata;
  logic [NP*BEW-1:0] req_be;
  logic [NP-1:0]    rsp_valid;
  logic [NP*DW-1:0] rsp_rdata;
  logic [CW-1:0]    conflict_cnt;

  int   n_checks = 0;
  int   n_pass   = 0;
  int   cyc      = 0;
  exp_t q0[$];
  exp_t q1[$];
  logic [31:0] model_mem [logic [9:0]];

  banked_mem_arb #(
    .DATA_WIDTH       (DW),
    .BYTE_ADDR_WIDTH  (8),
    .BANKS_ADDR_WIDTH (2),
    .NUM_PORTS        (NP),
    .CNT_WIDTH        (CW)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_wen      (req_wen),
    .req_addr     (req_addr),
    .req_wdata    (req_wdata),
    .req_be       (req_be),
    .rsp_valid    (rsp_valid),
    .rsp_rdata    (rsp_rdata),
    .conflict_cnt (conflict_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    else n_pass++;
  endtask

  task automatic set_port(input int p, input logic v, input logic w, input logic [9:0] a,
                          input logic [31:0] d, input logic [3:0] be);
    req_valid[p]          = v;
    req_wen[p]            = w;
    req_addr[p*AW +: AW]  = a;
    req_wdata[p*DW +: DW] = d;
    req_be[p*BEW +: BEW]  = be;
  endtask

  task automatic idle();
    set_port(0, 1'b0, 1'b0, 10'h000, 32'h0, 4'h0);
    set_port(1, 1'b0, 1'b0, 10'h000, 32'h0, 4'h0);
  endtask

  // Called just after a negedge: observes grants, updates the model, queues
  // expectations, then waits through the handshake edge to the next negedge.
  task automatic step(output logic [1:0] rdy);
    exp_t        e;
    logic [9:0]  a;
    logic [31:0] word;
    #1;
    rdy = req_ready;
    for (int p = 0; p < NP; p++) begin
      if (req_valid[p] && req_ready[p]) begin
        a = req_addr[p*AW +: AW];
        if (req_wen[p]) begin
          word = model_mem.exists(a) ? model_mem[a] : 32'h0;
          for (int i = 0; i < BEW; i++) begin
            if (req_be[p*BEW + i]) word[i*8 +: 8] = req_wdata[p*DW + i*8 +: 8];
          end
          model_mem[a] = word;
          e.data = 32'h0;
        end else begin
          e.data = model_mem[a];
        end
        e.due = cyc + 3;
        if (p == 0) q0.push_back(e);
        else        q1.push_back(e);
      end
    end
    @(negedge clk);
  endtask

  task automatic drain(input int n);
    logic [1:0] r;
    idle();
    for (int i = 0; i < n; i++) step(r);
  endtask

  // Response monitor: each pulse must match the head of its port's queue in time and data
  always @(negedge clk) begin : mon
    exp_t e;
    logic due_v;
    for (int p = 0; p < NP; p++) begin
      due_v  = 1'b0;
      e.data = 32'h0;
      e.due  = 0;
      if (p == 0 && q0.size() > 0) due_v = (q0[0].due == cyc);
      if (p == 1 && q1.size() > 0) due_v = (q1[0].due == cyc);
      if (due_v) begin
        if (p == 0) e = q0.pop_front();
        else        e = q1.pop_front();
      end
      if (rsp_valid[p] || due_v) begin
        check_eq($sformatf("rsp_valid_p%0d", p), 64'(rsp_valid[p]), 64'(due_v));
        if (rsp_valid[p] && due_v)
          check_eq($sformatf("rsp_rdata_p%0d", p), 64'(rsp_rdata[p*DW +: DW]), 64'(e.data));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, limit 200000 time units");
    $fatal(1);
  end

  initial begin
    logic [1:0] rdy;
    logic [1:0] hist [4];
    req_t       s0 [3];
    req_t       s1 [2];
    int         i0, i1, ncyc;

    // Reset state with requests already presented
    rst_n     = 1'b1;
    req_valid = '0; req_wen = '0; req_addr = '0; req_wdata = '0; req_be = '0;
    set_port(0, 1'b1, 1'b0, 10'h005, 32'h0, 4'h0);
    set_port(1, 1'b1, 1'b0, 10'h110, 32'h0, 4'h0);
    #1 rst_n = 1'b0;
    #2;
    check_eq("reset_req_ready", 64'(req_ready), 64'h0);
    check_eq("reset_rsp_valid", 64'(rsp_valid), 64'h0);
    check_eq("reset_rsp_rdata", 64'(rsp_rdata), 64'h0);
    check_eq("reset_conflict",  64'(conflict_cnt), 64'h0);
    repeat (2) @(negedge clk);
    idle();
    rst_n = 1'b1;

    // Basic write then read on port 0
    set_port(0, 1'b1, 1'b1, 10'h005, 32'hDEADBEEF, 4'hF);
    step(rdy); check_eq("wr_ready", 64'(rdy), 64'h1);
    set_port(0, 1'b1, 1'b0, 10'h005, 32'h0, 4'h0);
    step(rdy); check_eq("rd_ready", 64'(rdy), 64'h1);
    drain(4);

    // Byte enables: only bytes 0 and 2 cleared
    set_port(0, 1'b1, 1'b1, 10'h110, 32'hFFFFFFFF, 4'hF); step(rdy);
    set_port(0, 1'b1, 1'b1, 10'h110, 32'h00000000, 4'h5); step(rdy);
    set_port(0, 1'b1, 1'b0, 10'h110, 32'h0, 4'h0);        step(rdy);
    check_eq("be_read_ready", 64'(rdy), 64'h1);
    drain(4);

    // Parallel banks: both granted, no conflict counted
    set_port(0, 1'b1, 1'b1, 10'h010, 32'hA5A50010, 4'hF); step(rdy);
    set_port(0, 1'b1, 1'b0, 10'h010, 32'h0, 4'h0);
    set_port(1, 1'b1, 1'b0, 10'h110, 32'h0, 4'h0);
    step(rdy); check_eq("par_ready", 64'(rdy), 64'h3);
    drain(4);
    check_eq("par_conflict", 64'(conflict_cnt), 64'h0);

    // Round-robin on bank 2 with both ports streaming
    s0[0] = '{1'b1, 10'h200, 32'h11111111};
    s0[1] = '{1'b0, 10'h201, 32'h0};
    s0[2] = '{1'b1, 10'h202, 32'h33333333};
    s1[0] = '{1'b1, 10'h201, 32'h22222222};
    s1[1] = '{1'b0, 10'h200, 32'h0};
    for (int c = 0; c < 4; c++) hist[c] = 2'b00;
    i0 = 0; i1 = 0; ncyc = 0;
    while ((i0 < 3 || i1 < 2) && ncyc < 20) begin
      if (i0 < 3) set_port(0, 1'b1, s0[i0].w, s0[i0].a, s0[i0].d, 4'hF);
      else        set_port(0, 1'b0, 1'b0, 10'h000, 32'h0, 4'h0);
      if (i1 < 2) set_port(1, 1'b1, s1[i1].w, s1[i1].a, s1[i1].d, 4'hF);
      else        set_port(1, 1'b0, 1'b0, 10'h000, 32'h0, 4'h0);
      step(rdy);
      if (ncyc < 4) hist[ncyc] = rdy;
      if (rdy[0]) i0++;
      if (rdy[1]) i1++;
      ncyc++;
    end
    check_eq("rr_completed", 64'((i0 == 3) && (i1 == 2)), 64'h1);
    for (int c = 0; c < 4; c++)
      check_eq($sformatf("rr_grant_%0d", c), 64'(hist[c]), (c % 2 == 0) ? 64'h1 : 64'h2);
    idle();
    check_eq("rr_conflict", 64'(conflict_cnt), 64'h4);
    drain(4);

    // Sustained conflict on bank 3 saturates the 4-bit counter
    set_port(0, 1'b1, 1'b1, 10'h300, 32'h00003300, 4'hF);
    set_port(1, 1'b1, 1'b1, 10'h301, 32'h00003301, 4'hF);
    for (int c = 0; c < 20; c++) step(rdy);
    check_eq("sat_conflict", 64'(conflict_cnt), 64'hF);
    drain(4);

    // Reset with two reads in flight: responses dropped, outputs cleared at once
    set_port(0, 1'b1, 1'b0, 10'h300, 32'h0, 4'h0);
    set_port(1, 1'b1, 1'b0, 10'h110, 32'h0, 4'h0);
    step(rdy); check_eq("inflight_ready", 64'(rdy), 64'h3);
    #2 rst_n = 1'b0;
    q0.delete();
    q1.delete();
    #1;
    check_eq("midrst_req_ready", 64'(req_ready), 64'h0);
    check_eq("midrst_rsp_valid", 64'(rsp_valid), 64'h0);
    check_eq("midrst_rsp_rdata", 64'(rsp_rdata), 64'h0);
    check_eq("midrst_conflict",  64'(conflict_cnt), 64'h0);
    @(negedge clk);
    idle();
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    // Memory survives reset
    set_port(0, 1'b1, 1'b0, 10'h005, 32'h0, 4'h0);
    set_port(1, 1'b1, 1'b0, 10'h300, 32'h0, 4'h0);
    step(rdy); check_eq("post_rst_ready", 64'(rdy), 64'h3);
    drain(5);
    check_eq("scoreboard_empty", 64'(q0.size() + q1.size()), 64'h0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
